// File: rtl/lcd_pkg.sv
// Shared LCD geometry, pixel payload and frame-state types for the scan
// scheduler and the sprite generators.
package lcd_pkg;
  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;
  localparam int RGB_W      = 16;
  localparam int X_W        = 8;
  localparam int Y_W        = 9;
  localparam logic [RGB_W-1:0] TRANSPARENT = 16'h0000;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} frameState_t;

  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             last;
  } pixel_t;
endpackage

// File: rtl/pixel_skid_buf.sv
// One-entry hold buffer in front of an output register; inReady is purely
// registered, and inReadyNext tells the producer what it will be next cycle.
module pixel_skid_buf
  import lcd_pkg::*;
(
  input  logic   clock,
  input  logic   resetn,
  input  logic   inValid,
  input  pixel_t inData,
  output logic   inReady,
  output logic   inReadyNext,
  output logic   outValid,
  output pixel_t outData,
  input  logic   outReady
);
  logic   holdValid;
  pixel_t holdData;
  logic   push, outFree;

  assign inReady     = !holdValid;
  assign push        = inValid && inReady;
  assign outFree     = !outValid || outReady;
  // Hold is occupied next cycle only if the output is stuck and something is
  // already held or arriving now.
  assign inReadyNext = !((holdValid || push) && !outFree);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      holdValid <= 1'b0;
      holdData  <= '0;
      outValid  <= 1'b0;
      outData   <= '0;
    end else if (outFree) begin
      if (holdValid) begin
        outData   <= holdData;
        outValid  <= 1'b1;
        holdValid <= 1'b0;
      end else begin
        outValid <= push;
        if (push) outData <= inData;
      end
    end else if (push) begin
      holdData  <= inData;
      holdValid <= 1'b1;
    end
  end
endmodule

// File: rtl/lcd_frame_scheduler.sv
// Raster scan for one LCD frame: drives the sprite ROM addresses, absorbs their
// one-cycle latency and streams composed pixels to the LCD driver.
module lcd_frame_scheduler #(
  parameter int LCD_WIDTH  = lcd_pkg::LCD_WIDTH,
  parameter int LCD_HEIGHT = lcd_pkg::LCD_HEIGHT,
  parameter logic [lcd_pkg::RGB_W-1:0] BG_COLOUR = 16'h0000
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      frameStart,
  output logic [lcd_pkg::X_W-1:0]   xAddLCD,
  output logic [lcd_pkg::Y_W-1:0]   yAddLCD,
  input  logic [lcd_pkg::RGB_W-1:0] shipData,
  input  logic [lcd_pkg::RGB_W-1:0] overlayData,
  output logic [lcd_pkg::RGB_W-1:0] pixelOut,
  output logic [lcd_pkg::X_W-1:0]   pixelX,
  output logic [lcd_pkg::Y_W-1:0]   pixelY,
  output logic                      pixelWrite,
  input  logic                      pixelReady,
  output logic                      pixelLast,
  output logic                      frameBusy,
  output logic                      frameDone
);
  localparam int XW = lcd_pkg::X_W;
  localparam int YW = lcd_pkg::Y_W;
  localparam logic [XW-1:0] X_MAX = XW'(LCD_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(LCD_HEIGHT - 1);

  lcd_pkg::frameState_t state, stateNext;
  lcd_pkg::pixel_t      skidIn, skidOut;

  // A: address on the bus (aSeen once the ROM has sampled it).
  // B: previous address whose data is on the bus now, always accepted.
  logic          aValid, aSeen, bValid, bLast;
  logic [XW-1:0] bX;
  logic [YW-1:0] bY;
  logic          aLast, cand, pushOk, aPending, adv;
  logic          skidInReady, skidInReadyNext;

  assign aLast    = (xAddLCD == X_MAX) && (yAddLCD == Y_MAX);
  assign cand     = bValid || (aValid && aSeen);
  assign pushOk   = cand && skidInReady;
  assign aPending = aValid && !(pushOk && !bValid);
  // Issuing a new address turns a pending A into B, which must find a slot.
  assign adv      = (state == lcd_pkg::STREAM) && !aLast &&
                    (!aPending || skidInReadyNext);

  always_comb begin
    skidIn      = '0;
    skidIn.x    = bValid ? bX : xAddLCD;
    skidIn.y    = bValid ? bY : yAddLCD;
    skidIn.last = bValid ? bLast : aLast;
    if (overlayData != lcd_pkg::TRANSPARENT)   skidIn.rgb = overlayData;
    else if (shipData != lcd_pkg::TRANSPARENT) skidIn.rgb = shipData;
    else                                       skidIn.rgb = BG_COLOUR;
  end

  always_comb begin
    stateNext = state;
    frameBusy = 1'b0;
    frameDone = 1'b0;
    case (state)
      lcd_pkg::IDLE:   if (frameStart) stateNext = lcd_pkg::STREAM;
      lcd_pkg::STREAM: begin
        frameBusy = 1'b1;
        if (aLast) stateNext = lcd_pkg::DRAIN;
      end
      lcd_pkg::DRAIN: begin
        frameBusy = 1'b1;
        if (pixelWrite && pixelReady && pixelLast) stateNext = lcd_pkg::DONE;
      end
      lcd_pkg::DONE: begin
        frameDone = 1'b1;
        stateNext = lcd_pkg::IDLE;
      end
      default: stateNext = lcd_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= lcd_pkg::IDLE;
      xAddLCD <= '0;
      yAddLCD <= '0;
      aValid  <= 1'b0;
      aSeen   <= 1'b0;
      bValid  <= 1'b0;
      bX      <= '0;
      bY      <= '0;
      bLast   <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == lcd_pkg::IDLE && frameStart) begin
        xAddLCD <= '0;
        yAddLCD <= '0;
        aValid  <= 1'b1;
        aSeen   <= 1'b0;
        bValid  <= 1'b0;
      end else if (adv) begin
        bValid  <= aPending;
        bX      <= xAddLCD;
        bY      <= yAddLCD;
        bLast   <= aLast;
        xAddLCD <= (xAddLCD == X_MAX) ? '0 : xAddLCD + 1'b1;
        yAddLCD <= (xAddLCD == X_MAX) ? yAddLCD + 1'b1 : yAddLCD;
        aValid  <= 1'b1;
        aSeen   <= 1'b0;
      end else begin
        // Address held: the ROM re-reads it, so its data is on the bus next cycle.
        bValid <= 1'b0;
        aValid <= aPending;
        aSeen  <= aPending;
      end
    end
  end

  pixel_skid_buf uSkid (
    .clock       (clock),
    .resetn      (resetn),
    .inValid     (cand),
    .inData      (skidIn),
    .inReady     (skidInReady),
    .inReadyNext (skidInReadyNext),
    .outValid    (pixelWrite),
    .outData     (skidOut),
    .outReady    (pixelReady)
  );

  assign pixelOut  = skidOut.rgb;
  assign pixelX    = skidOut.x;
  assign pixelY    = skidOut.y;
  assign pixelLast = skidOut.last;
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed frame scans on a 240x8 raster with a registered ROM model.
module tb_lcd_frame_scheduler;
  localparam int W = 240;
  localparam int H = 8;
  localparam int N = W * H;
  localparam logic [15:0] BG = 16'h001F;

  logic        clock = 1'b0, resetn = 1'b0, frameStart = 1'b0, pixelReady = 1'b0;
  logic [7:0]  xAddLCD, pixelX;
  logic [8:0]  yAddLCD, pixelY;
  logic [15:0] shipData = '0, overlayData = '0, pixelOut;
  logic        pixelWrite, pixelLast, frameBusy, frameDone;
  int          nAssert = 0, nFail = 0;

  lcd_frame_scheduler #(.LCD_WIDTH(W), .LCD_HEIGHT(H), .BG_COLOUR(BG)) dut (
    .clock(clock), .resetn(resetn), .frameStart(frameStart),
    .xAddLCD(xAddLCD), .yAddLCD(yAddLCD),
    .shipData(shipData), .overlayData(overlayData),
    .pixelOut(pixelOut), .pixelX(pixelX), .pixelY(pixelY),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady), .pixelLast(pixelLast),
    .frameBusy(frameBusy), .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  // Row 1: x<10 ship only, 10..19 overlay over ship, 20..29 both transparent.
  function automatic logic [15:0] shipFn(input logic [7:0] x, input logic [8:0] y);
    if (y == 9'd1 && x < 8'd20) return 16'hF800;
    if (y == 9'd1 && x < 8'd30) return 16'h0000;
    return 16'(int'(x) + 240 * int'(y));
  endfunction

  function automatic logic [15:0] ovFn(input logic [7:0] x, input logic [8:0] y);
    if (y == 9'd1 && x >= 8'd10 && x < 8'd20) return 16'h07E0;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] expPix(input int idx);
    int x, y;
    x = idx % W;
    y = idx / W;
    if (y == 1 && x < 10) return 16'hF800;
    if (y == 1 && x < 20) return 16'h07E0;
    if (y == 1 && x < 30) return BG;
    if (idx == 0) return BG;
    return 16'(idx);
  endfunction

  always @(posedge clock) begin
    shipData    <= shipFn(xAddLCD, yAddLCD);
    overlayData <= ovFn(xAddLCD, yAddLCD);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".xAdd"}, xAddLCD, 0);
    check({tag, ".yAdd"}, yAddLCD, 0);
    check({tag, ".pixelOut"}, pixelOut, 0);
    check({tag, ".pixelX"}, pixelX, 0);
    check({tag, ".pixelY"}, pixelY, 0);
    check({tag, ".pixelWrite"}, pixelWrite, 0);
    check({tag, ".pixelLast"}, pixelLast, 0);
    check({tag, ".frameBusy"}, frameBusy, 0);
    check({tag, ".frameDone"}, frameDone, 0);
  endtask

  // mode 0: ready high + ignored frameStart; 1: random ready;
  // 2: 5-cycle stall on (17,0); 3: reset at pixel 1000
  task automatic runFrame(input int mode);
    int idx = 0, doneCnt = 0, lastCyc = -100, stall = 0;
    @(negedge clock);
    frameStart = 1'b1;
    pixelReady = 1'b1;
    @(negedge clock);
    frameStart = 1'b0;
    if (mode == 0) begin
      check("busyRise", frameBusy, 1);
      check("firstAddr", {xAddLCD, yAddLCD}, 0);
    end
    for (int cyc = 0; cyc < 4 * N + 100; cyc++) begin
      pixelReady = 1'b1;
      frameStart = 1'b0;
      if (mode == 1) pixelReady = 1'($urandom_range(0, 1));
      if (mode == 0 && cyc == 500) frameStart = 1'b1;
      if (mode == 2 && idx == 17 && stall < 5) begin
        pixelReady = 1'b0;
        stall++;
        check("stallX", pixelX, 17);
        check("stallY", pixelY, 0);
        check("stallPix", pixelOut, 17);
        check("stallWrite", pixelWrite, 1);
      end
      if (mode == 3 && idx == 1000) begin
        resetn = 1'b0;
        @(negedge clock);
        checkReset("midReset");
        resetn = 1'b1;
        return;
      end
      if (mode == 0 && cyc == 1) check("noWriteC1", pixelWrite, 0);
      if (mode == 0 && cyc == 2) check("firstWriteC2", pixelWrite, 1);
      if (mode != 1 && idx > 0 && idx < N) check("noBubble", pixelWrite, 1);
      if (frameDone) begin
        doneCnt++;
        check("doneTiming", cyc, lastCyc + 1);
        check("doneAfterAll", idx, N);
      end
      if (pixelWrite && pixelReady) begin
        check("xferX", pixelX, idx % W);
        check("xferY", pixelY, idx / W);
        check("xferPix", pixelOut, expPix(idx));
        check("xferLast", pixelLast, (idx == N - 1) ? 1 : 0);
        idx++;
        if (idx == N) lastCyc = cyc;
      end
      if (doneCnt > 0 && cyc >= lastCyc + 12) break;
      @(negedge clock);
    end
    check("doneOnce", doneCnt, 1);
    check("xferCount", idx, N);
    check("idleBusy", frameBusy, 0);
    check("idleWrite", pixelWrite, 0);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checkReset("reset");
    resetn = 1'b1;
    @(negedge clock);
    check("idleAfterReset", {frameBusy, pixelWrite}, 0);
    runFrame(0);
    runFrame(1);
    runFrame(2);
    runFrame(3);
    runFrame(0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
